// File: rtl/mem_write_buffer.sv
// mem_write_buffer
//   Posted-write buffer between the CPU memory port and main memory. CPU
//   requests arrive on a single-outstanding read/write/resp handshake and are
//   reissued downstream on the same handshake. Writes are acknowledged early
//   and queued; reads wait until every older write has drained. A sticky
//   protocol_error flags illegal activity on either side.
//
//   Build option: WRITE_BUFFER_POST_EN
//     defined   - write FIFO built, writes posted (ack one cycle after accept)
//     undefined - no FIFO, wb_count tied to 0, writes complete like reads
//
//   Ports
//     clk, rst            clock; synchronous active-low reset
//     cpu_read/cpu_write  CPU strobes, held until cpu_resp
//     cpu_byte_enable     write byte lanes
//     cpu_address         request address
//     cpu_wdata           write data
//     cpu_resp            one-cycle completion pulse
//     cpu_rdata           read data, valid with cpu_resp
//     mem_read/mem_write  downstream strobes
//     mem_byte_enable     downstream lanes
//     mem_address         downstream address
//     mem_wdata           downstream data
//     mem_resp            downstream completion pulse
//     mem_rdata           downstream read data, valid with mem_resp
//     wb_count            occupied write-buffer entries (0..DEPTH)
//     protocol_error      sticky violation flag
module mem_write_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_read,
  input  logic                   cpu_write,
  input  logic [3:0]             cpu_byte_enable,
  input  logic [31:0]            cpu_address,
  input  logic [31:0]            cpu_wdata,
  output logic                   cpu_resp,
  output logic [31:0]            cpu_rdata,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [3:0]             mem_byte_enable,
  output logic [31:0]            mem_address,
  output logic [31:0]            mem_wdata,
  input  logic                   mem_resp,
  input  logic [31:0]            mem_rdata,
  output logic [$clog2(DEPTH):0] wb_count,
  output logic                   protocol_error
);

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  state_t      state_q, state_d;
  logic        mem_read_d, mem_write_d, cpu_resp_d, err_d;
  logic [3:0]  be_d;
  logic [31:0] addr_d, wdata_d, rdata_d;
  logic [1:0]  guard_q;
  logic        guard_done;
  logic        req_ok;

  // The cycle carrying cpu_resp still shows the answered request; never
  // accept it twice. Simultaneous read+write is illegal and never accepted.
  assign req_ok     = !cpu_resp && !(cpu_read && cpu_write);
  // Stray mem_resp is tolerated for the first two cycles out of reset.
  assign guard_done = (guard_q == 2'd2);

`ifdef WRITE_BUFFER_POST_EN
  localparam int unsigned PW = $clog2(DEPTH);

  logic [31:0]   fifo_addr [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [3:0]    fifo_be   [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          push, pop, full, empty;

  // Fullness uses the registered count, so a same-cycle pop never frees a
  // slot for that cycle's push.
  assign full  = (wb_count == (PW+1)'(DEPTH));
  assign empty = (wb_count == '0);
  assign push  = cpu_write && req_ok && !full;
`else
  assign wb_count = '0;
`endif

  always_comb begin
    state_d     = state_q;
    mem_read_d  = mem_read;
    mem_write_d = mem_write;
    be_d        = mem_byte_enable;
    addr_d      = mem_address;
    wdata_d     = mem_wdata;
    rdata_d     = cpu_rdata;
    cpu_resp_d  = 1'b0;
`ifdef WRITE_BUFFER_POST_EN
    pop         = 1'b0;
    cpu_resp_d  = push;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef WRITE_BUFFER_POST_EN
        if (!empty) begin
          state_d     = WR;
          mem_write_d = 1'b1;
          addr_d      = fifo_addr[rd_ptr];
          be_d        = fifo_be[rd_ptr];
          wdata_d     = fifo_data[rd_ptr];
        end else if (cpu_read && req_ok) begin
          state_d    = RD;
          mem_read_d = 1'b1;
          addr_d     = cpu_address;
        end
`else
        if (cpu_write && req_ok) begin
          state_d     = WR;
          mem_write_d = 1'b1;
          addr_d      = cpu_address;
          be_d        = cpu_byte_enable;
          wdata_d     = cpu_wdata;
        end else if (cpu_read && req_ok) begin
          state_d    = RD;
          mem_read_d = 1'b1;
          addr_d     = cpu_address;
        end
`endif
      end
      WR: begin
        if (mem_resp) begin
          state_d     = IDLE;
          mem_write_d = 1'b0;
`ifdef WRITE_BUFFER_POST_EN
          pop         = 1'b1;
`else
          cpu_resp_d  = 1'b1;
`endif
        end
      end
      RD: begin
        if (mem_resp) begin
          state_d    = IDLE;
          mem_read_d = 1'b0;
          rdata_d    = mem_rdata;
          cpu_resp_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign err_d = protocol_error || (cpu_read && cpu_write) ||
                 (mem_resp && (state_q == IDLE) && guard_done);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= IDLE;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_byte_enable <= '0;
      mem_address     <= '0;
      mem_wdata       <= '0;
      cpu_resp        <= 1'b0;
      cpu_rdata       <= '0;
      protocol_error  <= 1'b0;
      guard_q         <= '0;
    end else begin
      state_q         <= state_d;
      mem_read        <= mem_read_d;
      mem_write       <= mem_write_d;
      mem_byte_enable <= be_d;
      mem_address     <= addr_d;
      mem_wdata       <= wdata_d;
      cpu_resp        <= cpu_resp_d;
      cpu_rdata       <= rdata_d;
      protocol_error  <= err_d;
      if (!guard_done) guard_q <= guard_q + 2'd1;
    end
  end

`ifdef WRITE_BUFFER_POST_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      wb_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      wb_count <= wb_count + 1'b1;
      else if (pop && !push) wb_count <= wb_count - 1'b1;
    end
  end

  // Storage is not reset; contents are meaningless once the pointers clear.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= cpu_address;
      fifo_data[wr_ptr] <= cpu_wdata;
      fifo_be[wr_ptr]   <= cpu_byte_enable;
    end
  end
`endif

endmodule

// File: doc/mem_write_buffer.md
# mem_write_buffer

Posted-write buffer between the CPU memory port and the main memory model. Accepts CPU requests on the single-outstanding read/write/resp handshake and reissues them downstream on an identical handshake. Writes are acknowledged early and queued in a small FIFO, and reads are held until all older writes have drained. Also raises a sticky flag on protocol violations seen on either side.

## Interface
- DEPTH, 4, write FIFO entries; power of two, ≥2
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-low reset
- cpu_read / cpu_write  in  1  CPU request strobes; held until cpu_resp
- cpu_byte_enable  in  4  byte lanes of a write
- cpu_address  in  32  request address
- cpu_wdata  in  32  write data
- cpu_resp  out  1  one-cycle completion pulse
- cpu_rdata  out  32  read data, valid while cpu_resp=1
- mem_read / mem_write  out  1  downstream request strobes
- mem_byte_enable  out  4  downstream lanes
- mem_address  out  32  downstream address
- mem_wdata  out  32  downstream data
- mem_resp  in  1  downstream completion pulse
- mem_rdata  in  32  downstream read data, valid with mem_resp
- wb_count  out  $clog2(DEPTH)+1  occupied FIFO entries
- protocol_error  out  1  sticky violation flag

## Operation
- Handshake on both sides:
  - Requester holds strobe, address, lanes and data stable until resp.
  - Resp lasts exactly one cycle.
  - read and write are never high together.
- All outputs are registered. Reset values are 0 for every output. State is IDLE and the FIFO is empty.
- Upstream acceptance:
  - No request is accepted in a cycle where cpu_resp=1. That cycle repeats the answered request.
  - **CPU write:**
    - If the FIFO is not full, push {address, byte_enable, wdata} and drive cpu_resp=1 on the next cycle.
    - If the FIFO is full, the write stalls. A pop in the same cycle does not free a slot for that cycle's push.
  - **CPU read:**
    - Accepted only when the FIFO is empty and the downstream FSM is IDLE.
    - Otherwise the read waits.
- Downstream FSM, states IDLE, WR, RD:
  - IDLE→WR when the FIFO is non-empty. Drive mem_write with the head entry.
  - IDLE→RD when a read is accepted. Drive mem_read with cpu_address.
  - WR: on mem_resp, pop the head, deassert mem_write, →IDLE.
  - RD: on mem_resp, latch mem_rdata into cpu_rdata, pulse cpu_resp next cycle, deassert mem_read, →IDLE.
  - Every transaction is followed by at least one IDLE cycle with the strobes low.
- Writes always drain before a pending read, so memory ordering is preserved.
- FIFO pointers wrap modulo DEPTH. wb_count ranges from 0 to DEPTH.
- protocol_error is set and held until reset on any of:
  - cpu_read & cpu_write
  - mem_resp while in IDLE, except in the first 2 cycles after rst deasserts; a stray mem_resp there is ignored.
- Reset mid-operation:
  - Strobes drop at the reset edge.
  - FIFO contents are discarded; queued writes are lost.
  - No cpu_resp is issued for the interrupted request.

## Timing
- Posted write: cpu_resp at cycle N+1 for acceptance at N.
- Read: mem_read rises 1 cycle after acceptance. cpu_resp follows 1 cycle after mem_resp. Total latency is memory latency + 2.
- Write drain: mem_write rises 1 cycle after IDLE with non-empty FIFO. Back-to-back drains are spaced by one IDLE cycle.
- wb_count updates on the cycle after push/pop.

## Configuration
- WRITE_BUFFER_POST_EN defined:
  - Posted-write behaviour as above.
- WRITE_BUFFER_POST_EN undefined:
  - The FIFO is not built and wb_count is tied to 0.
  - Writes follow the read path: IDLE→WR with CPU fields, and cpu_resp 1 cycle after mem_resp.

## Test plan
- Reset: hold rst=0 3 cycles with cpu_write=1 → all outputs 0, no cpu_resp, wb_count=0.
- Single posted write 0x100 / 0xDEADBEEF / be=0xF with memory latency 5 → cpu_resp at +1; mem_write with identical fields at +2; wb_count 1→0 after mem_resp.
- Fill: 5 writes with DEPTH=4 and memory stalled → 4 acks, 5th stalls with wb_count=4; first mem_resp frees a slot and the 5th acks after the pop.
- Read-after-write: write 0x200=0x12345678 then read 0x200 → mem_read only after mem_write completes; cpu_rdata=0x12345678 one cycle after the read's mem_resp.
- Violation: cpu_read=cpu_write=1 for one cycle → protocol_error=1, held until rst=0.
- Mid-drain reset: rst=0 while mem_write=1 with 3 queued entries → mem_write=0 at the next edge, wb_count=0, no cpu_resp.
